// File: rtl/fetch_controller.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_controller
//  Description : IF-stage fetch sequencer. Owns the fetch PC, drives the
//                combinational instruction-memory address, and buffers
//                fetched {pc, instr} pairs in a small prefetch FIFO that feeds
//                the IF/ID register. Absorbs decode stalls and flushes on
//                branch/jump redirect.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_controller #(
  parameter int unsigned       ADDR_W     = 64,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int unsigned       FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_instr,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [ADDR_W-1:0] if_pc,
  output logic [31:0]       if_instr,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              misalign_err,
  output logic [2:0]        fifo_count
);

  // Pointer width indexes the storage; count needs one extra value so that
  // "full" and "empty" are distinct without a wrap bit on the pointers.
  localparam int unsigned       c_PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned       c_CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam logic [c_CNT_W-1:0] c_DEPTH  = c_CNT_W'(FIFO_DEPTH);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
  localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);
  localparam logic [ADDR_W-1:0] c_PC_STEP = ADDR_W'(4);

  logic [ADDR_W-1:0]  r_fetch_pc;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_CNT_W-1:0] r_count;
  logic               r_misalign;
  logic [ADDR_W-1:0]  r_pc_mem    [FIFO_DEPTH];
  logic [31:0]        r_instr_mem [FIFO_DEPTH];

  logic w_not_empty;
  logic w_pop;
  logic w_push;

  // Handshake decode: a redirect suppresses both sides so the head presented
  // in the redirect cycle is never consumed and nothing stale is enqueued.
  always_comb begin
    w_not_empty = (r_count != '0);
    w_pop       = w_not_empty & if_ready & ~redirect_valid;
    w_push      = fetch_en & ~r_misalign & ~redirect_valid &
                  ((r_count < c_DEPTH) | w_pop);
  end

  // Fetch PC, pointers, occupancy and the sticky misalignment flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fetch_pc <= RESET_PC;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_misalign <= 1'b0;
    end else if (redirect_valid) begin
      r_fetch_pc <= redirect_pc;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_misalign <= |redirect_pc[1:0];
    end else begin
      if (w_push) begin
        r_wr_ptr   <= r_wr_ptr + c_PTR_ONE;
        r_fetch_pc <= r_fetch_pc + c_PC_STEP;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_ONE;
        2'b01:   r_count <= r_count - c_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Prefetch storage; cleared on reset so the head reads as zero afterwards.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_pc_mem[i]    <= '0;
        r_instr_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_pc_mem[r_wr_ptr]    <= r_fetch_pc;
      r_instr_mem[r_wr_ptr] <= imem_instr;
    end
  end

  // Output mapping: memory address tracks the fetch PC, head entry drives IF/ID.
  always_comb begin
    imem_addr    = r_fetch_pc;
    if_valid     = w_not_empty;
    if_pc        = r_pc_mem[r_rd_ptr];
    if_instr     = r_instr_mem[r_rd_ptr];
    misalign_err = r_misalign;
    fifo_count   = 3'(r_count);
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_controller
//  Description : Self-checking bench for fetch_controller. A queue-based
//                reference model of the prefetch buffer is stepped alongside
//                the design under directed and randomized stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_en;
  logic [63:0] imem_addr;
  logic [31:0] imem_instr;
  logic        if_valid;
  logic        if_ready;
  logic [63:0] if_pc;
  logic [31:0] if_instr;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        misalign_err;
  logic [2:0]  fifo_count;
  logic [7:0]  seed;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        q[$];
  logic [63:0] m_pc;
  logic        m_mis;

  always #5 clk = ~clk;

  // Instruction memory: byte contents are a hash of the address, words are big-endian.
  function automatic logic [31:0] instr_at(input logic [63:0] a, input logic [7:0] s);
    logic [31:0] r;
    logic [63:0] ad;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      ad = a + 64'(k);
      r  = {r[23:0], 8'(ad[7:0] * 8'd151) ^ ad[15:8] ^ ad[63:56] ^ s};
    end
    return r;
  endfunction

  assign imem_instr = instr_at(imem_addr, seed);

  fetch_controller dut (
    .clk            (clk),
    .reset          (reset),
    .fetch_en       (fetch_en),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .misalign_err   (misalign_err),
    .fifo_count     (fifo_count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ":imem_addr"}, imem_addr, m_pc);
    check({tag, ":if_valid"}, 64'(if_valid), 64'(q.size() != 0));
    check({tag, ":fifo_count"}, 64'(fifo_count), 64'(q.size()));
    check({tag, ":misalign"}, 64'(misalign_err), 64'(m_mis));
    if (q.size() != 0) begin
      check({tag, ":if_pc"}, if_pc, q[0].pc);
      check({tag, ":if_instr"}, 64'(if_instr), 64'(q[0].instr));
    end
  endtask

  // Reference model: one clock of the prefetch buffer from the current inputs.
  task automatic model_step();
    bit pop, push;
    pop  = (q.size() != 0) && if_ready && !redirect_valid;
    push = fetch_en && !m_mis && !redirect_valid && ((q.size() < 4) || pop);
    if (redirect_valid) begin
      q.delete();
      m_pc  = redirect_pc;
      m_mis = (redirect_pc[1:0] != 2'b00);
    end else begin
      if (pop) void'(q.pop_front());
      if (push) begin
        q.push_back('{pc: m_pc, instr: instr_at(m_pc, seed)});
        m_pc = m_pc + 64'd4;
      end
    end
  endtask

  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  // Assert reset between edges, check the asynchronous clear, release after an edge.
  task automatic do_reset(input string tag);
    reset = 1'b1;
    #1;
    q.delete();
    m_pc  = 64'h0;
    m_mis = 1'b0;
    compare_all(tag);
    check({tag, ":if_pc0"}, if_pc, 64'h0);
    check({tag, ":if_instr0"}, 64'(if_instr), 64'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    seed           = 8'($urandom);
    reset          = 1'b1;
    fetch_en       = 1'b1;
    if_ready       = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 64'h0;
    q.delete();
    m_pc  = 64'h0;
    m_mis = 1'b0;
    @(posedge clk);
    #1;
    compare_all("reset");
    check("reset:if_pc0", if_pc, 64'h0);
    check("reset:if_instr0", 64'(if_instr), 64'h0);
    reset = 1'b0;

    // Streaming from reset with decode always ready.
    for (int i = 0; i < 6; i++) begin
      tick("t1");
      check("t1:pc_seq", if_pc, 64'(i * 4));
    end

    // Stall from reset until full, then release with no bubble.
    if_ready = 1'b0;
    do_reset("t2_rst");
    for (int i = 0; i < 6; i++) tick("t2_fill");
    check("t2:full", 64'(fifo_count), 64'd4);
    check("t2:addr_hold", imem_addr, 64'h10);
    check("t2:head_hold", if_pc, 64'h0);
    if_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick("t2_drain");
      check("t2:no_gap", if_pc, 64'((i + 1) * 4));
      check("t2:count_full", 64'(fifo_count), 64'd4);
    end

    // Redirect while full and stalled.
    if_ready = 1'b0;
    tick("t3_stall");
    redirect_valid = 1'b1;
    redirect_pc    = 64'h100;
    tick("t3_redir");
    check("t3:flushed", 64'(fifo_count), 64'd0);
    check("t3:invalid", 64'(if_valid), 64'd0);
    redirect_valid = 1'b0;
    tick("t3_n2");
    check("t3:target", if_pc, 64'h100);
    if_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick("t3_run");

    // Misaligned redirect blocks fetch until an aligned one.
    redirect_valid = 1'b1;
    redirect_pc    = 64'h102;
    tick("t4_bad");
    check("t4:err_set", 64'(misalign_err), 64'd1);
    redirect_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick("t4_blocked");
      check("t4:no_push", 64'(fifo_count), 64'd0);
    end
    redirect_valid = 1'b1;
    redirect_pc    = 64'h200;
    tick("t4_good");
    check("t4:err_clr", 64'(misalign_err), 64'd0);
    redirect_valid = 1'b0;
    tick("t4_n2");
    check("t4:target", if_pc, 64'h200);

    // fetch_en low drains three entries and freezes the address.
    redirect_valid = 1'b1;
    redirect_pc    = 64'h300;
    tick("t5_redir");
    redirect_valid = 1'b0;
    if_ready       = 1'b0;
    for (int i = 0; i < 3; i++) tick("t5_fill");
    check("t5:three", 64'(fifo_count), 64'd3);
    fetch_en = 1'b0;
    if_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick("t5_drain");
      check("t5:frozen", imem_addr, 64'h30c);
    end
    check("t5:empty", 64'(if_valid), 64'd0);
    fetch_en = 1'b1;
    tick("t5_resume");
    check("t5:resume_pc", if_pc, 64'h30c);

    // Reset mid-stream with three entries held.
    if_ready = 1'b0;
    for (int i = 0; i < 2; i++) tick("t6_fill");
    check("t6:three", 64'(fifo_count), 64'd3);
    do_reset("t6_rst");
    if_ready = 1'b1;
    tick("t6_resume");
    check("t6:resume_pc", if_pc, 64'h0);

    // PC wrap at the top of the address space.
    redirect_valid = 1'b1;
    redirect_pc    = 64'hFFFF_FFFF_FFFF_FFF8;
    tick("wrap_redir");
    redirect_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if_ready = 1'($urandom_range(0, 1));
      tick("wrap");
    end

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      fetch_en       = ($urandom_range(0, 7) != 0);
      if_ready       = ($urandom_range(0, 2) != 0);
      redirect_valid = ($urandom_range(0, 11) == 0);
      redirect_pc    = {32'($urandom), 32'($urandom)};
      if ($urandom_range(0, 7) != 0) redirect_pc[1:0] = 2'b00;
      if ($urandom_range(0, 15) == 0) redirect_pc = 64'hFFFF_FFFF_FFFF_FFF0;
      tick("rand");
    end
    redirect_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
